// File: rtl/turn_controller_pkg.sv
// Shared tic-tac-toe definitions: player encodings, controller states, cell limits.
package ttt_pkg;

  typedef enum logic [1:0] {
    NONE = 2'b00,
    P1   = 2'b01,
    P2   = 2'b10
  } player_e;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    CHECK,
    DONE
  } state_e;

  localparam logic [3:0] CELL_MIN  = 4'd1;
  localparam logic [3:0] CELL_MAX  = 4'd9;
  localparam logic [3:0] MAX_MOVES = 4'd9;

  function automatic logic cell_ok(input logic [3:0] code);
    return (code >= CELL_MIN) && (code <= CELL_MAX);
  endfunction

  function automatic player_e other_player(input player_e p);
    return (p == P1) ? P2 : P1;
  endfunction

endpackage

// File: rtl/turn_controller_if.sv
// Keypad / board-block signal bundle seen by the turn controller.
interface turn_controller_if;
  logic       key_valid;
  logic [3:0] key_code;
  logic       illegal_move;
  logic       over;
  logic       move_P1_i;
  logic       move_P2_i;
  logic [3:0] move_P1;
  logic [3:0] move_P2;
  logic [1:0] turn;
  logic [3:0] move_count;
  logic       key_reject;
  logic       timeout;
  logic       draw;
  logic       done;

  modport master (
    output key_valid, key_code, illegal_move, over,
    input  move_P1_i, move_P2_i, move_P1, move_P2, turn, move_count,
           key_reject, timeout, draw, done
  );

  modport slave (
    input  key_valid, key_code, illegal_move, over,
    output move_P1_i, move_P2_i, move_P1, move_P2, turn, move_count,
           key_reject, timeout, draw, done
  );
endinterface

// File: rtl/turn_controller_move_timer.sv
// Idle-cycle counter; pulses expire_o on the last idle cycle and wraps to zero.
module move_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 100_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic enable_i,
  input  logic clear_i,
  output logic expire_o
);
  localparam int unsigned W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [W-1:0] LAST = (TIMEOUT_CYCLES > 0) ? W'(TIMEOUT_CYCLES - 1) : '0;

  logic [W-1:0] count_q, count_d;

  // A zero timeout disables expiry entirely.
  assign expire_o = (TIMEOUT_CYCLES != 0) && enable_i && (count_q == LAST);

  always_comb begin
    count_d = count_q;
    if (clear_i || expire_o) count_d = '0;
    else if (enable_i)       count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end
endmodule

// File: rtl/turn_controller.sv
// Tic-tac-toe turn sequencer: accepts keypad cells, strobes moves to the board
// block, tracks turn/move count and ends the game on win, draw or over.
module turn_controller
  import ttt_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 100_000_000
) (
  input  logic              clk,
  input  logic              reset,
  turn_controller_if.slave  bus
);
  state_e     state_q, state_d;
  player_e    turn_q, turn_d;
  logic [3:0] count_q, count_d;
  logic       p1_i_q, p1_i_d, p2_i_q, p2_i_d;
  logic [3:0] p1_q, p1_d, p2_q, p2_d;
  logic       rej_q, rej_d, to_q, to_d;
  logic       draw_q, draw_d, done_q, done_d;
  logic       expire, leave_idle;

  assign leave_idle = (state_q == IDLE) && (state_d != IDLE);

  move_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk      (clk),
    .rst      (reset),
    .enable_i (state_q == IDLE),
    .clear_i  (leave_idle),
    .expire_o (expire)
  );

  always_comb begin
    state_d = state_q;
    turn_d  = turn_q;
    count_d = count_q;
    p1_i_d  = 1'b0;
    p2_i_d  = 1'b0;
    p1_d    = 4'd0;
    p2_d    = 4'd0;
    rej_d   = 1'b0;
    to_d    = 1'b0;
    draw_d  = draw_q;
    unique case (state_q)
      IDLE: begin
        // A key on the expiry cycle takes precedence over the timeout.
        if (bus.over) begin
          state_d = DONE;
        end else if (bus.key_valid) begin
          if (cell_ok(bus.key_code)) begin
            state_d = ISSUE;
            if (turn_q == P1) begin
              p1_i_d = 1'b1;
              p1_d   = bus.key_code;
            end else begin
              p2_i_d = 1'b1;
              p2_d   = bus.key_code;
            end
          end else begin
            rej_d = 1'b1;
          end
        end else if (expire) begin
          to_d   = 1'b1;
          turn_d = other_player(turn_q);
        end
      end
      ISSUE: state_d = CHECK;
      CHECK: begin
        state_d = IDLE;
        if (!bus.illegal_move) begin
          count_d = count_q + 4'd1;
          turn_d  = other_player(turn_q);
          if (bus.over) begin
            state_d = DONE;
          end else if (count_d == MAX_MOVES) begin
            state_d = DONE;
            draw_d  = 1'b1;
          end
        end
      end
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      turn_q  <= P1;
      count_q <= 4'd0;
      p1_i_q  <= 1'b0;
      p2_i_q  <= 1'b0;
      p1_q    <= 4'd0;
      p2_q    <= 4'd0;
      rej_q   <= 1'b0;
      to_q    <= 1'b0;
      draw_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      turn_q  <= turn_d;
      count_q <= count_d;
      p1_i_q  <= p1_i_d;
      p2_i_q  <= p2_i_d;
      p1_q    <= p1_d;
      p2_q    <= p2_d;
      rej_q   <= rej_d;
      to_q    <= to_d;
      draw_q  <= draw_d;
      done_q  <= done_d;
    end
  end

  assign bus.move_P1_i  = p1_i_q;
  assign bus.move_P2_i  = p2_i_q;
  assign bus.move_P1    = p1_q;
  assign bus.move_P2    = p2_q;
  assign bus.turn       = turn_q;
  assign bus.move_count = count_q;
  assign bus.key_reject = rej_q;
  assign bus.timeout    = to_q;
  assign bus.draw       = draw_q;
  assign bus.done       = done_q;
endmodule

// File: tb/tb_turn_controller.sv
// Scoreboard bench for turn_controller: pulses are queued as expectations and
// matched by a monitor; turn/count/end flags are checked at fixed points.
module tb_turn_controller;
  localparam logic [1:0] PL1 = 2'b01;
  localparam logic [1:0] PL2 = 2'b10;

  typedef enum int {K_STROBE, K_REJECT, K_TIMEOUT} kind_e;
  typedef struct {
    kind_e      kind;
    logic [1:0] who;
    logic [3:0] code;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb[$];

  turn_controller_if bus();

  turn_controller #(.TIMEOUT_CYCLES(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int want);
    n_cmp++;
    if (act != want) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, want);
    end
  endtask

  task automatic pop_check(input kind_e kind);
    exp_t       e;
    logic [9:0] act, want;
    n_cmp++;
    if (sb.size() == 0) begin
      n_bad++;
      $display("FAIL unexpected_pulse: got kind %0d, want none", kind);
    end else begin
      e = sb.pop_front();
      act  = {bus.move_P1_i, bus.move_P2_i, bus.move_P1, bus.move_P2};
      want = {e.who == PL1, e.who == PL2,
              (e.who == PL1) ? e.code : 4'd0, (e.who == PL2) ? e.code : 4'd0};
      if (e.kind != kind) begin
        n_bad++;
        $display("FAIL pulse_kind: got %0d, want %0d", kind, e.kind);
      end else if (kind == K_STROBE && act != want) begin
        n_bad++;
        $display("FAIL strobe: got %h, want %h", act, want);
      end
    end
  endtask

  // Monitor: every output pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (bus.move_P1_i || bus.move_P2_i) begin
      pop_check(K_STROBE);
    end else begin
      n_cmp++;
      if (bus.move_P1 != 4'd0 || bus.move_P2 != 4'd0) begin
        n_bad++;
        $display("FAIL idle_codes: got %0d/%0d, want 0/0", bus.move_P1, bus.move_P2);
      end
    end
    if (bus.key_reject) pop_check(K_REJECT);
    if (bus.timeout)    pop_check(K_TIMEOUT);
  end

  task automatic push(input kind_e kind, input logic [1:0] who, input logic [3:0] code);
    exp_t e;
    e.kind = kind;
    e.who  = who;
    e.code = code;
    sb.push_back(e);
  endtask

  task automatic play(input logic [3:0] code, input logic [1:0] who,
                      input logic illegal, input logic set_over);
    push(K_STROBE, who, code);
    bus.key_code     = code;
    bus.key_valid    = 1'b1;
    bus.illegal_move = illegal;
    @(negedge clk);
    bus.key_valid = 1'b0;
    bus.key_code  = 4'd0;
    if (set_over) bus.over = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus.illegal_move = 1'b0;
  endtask

  task automatic reject(input logic [3:0] code);
    push(K_REJECT, 2'b00, 4'd0);
    bus.key_code  = code;
    bus.key_valid = 1'b1;
    @(negedge clk);
    bus.key_valid = 1'b0;
    bus.key_code  = 4'd0;
  endtask

  task automatic drop(input logic [3:0] code);
    bus.key_code  = code;
    bus.key_valid = 1'b1;
    @(negedge clk);
    bus.key_valid = 1'b0;
    bus.key_code  = 4'd0;
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.over = 1'b0;
    @(negedge clk);
    chk("rst_turn", bus.turn, PL1);
    chk("rst_count", bus.move_count, 0);
    chk("rst_flags", {bus.done, bus.draw, bus.key_reject, bus.timeout}, 0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic [3:0] seq [7] = '{4'd1, 4'd2, 4'd4, 4'd6, 4'd7, 4'd8, 4'd9};
    bus.key_valid    = 1'b0;
    bus.key_code     = 4'd0;
    bus.illegal_move = 1'b0;
    bus.over         = 1'b0;
    @(negedge clk);
    do_reset();

    // Legal move, illegal retry, rejects, then play out to a draw.
    play(4'd5, PL1, 1'b0, 1'b0);
    chk("m1_turn", bus.turn, PL2);
    chk("m1_count", bus.move_count, 1);
    play(4'd5, PL2, 1'b1, 1'b0);
    chk("illegal_turn", bus.turn, PL2);
    chk("illegal_count", bus.move_count, 1);
    play(4'd3, PL2, 1'b0, 1'b0);
    chk("retry_turn", bus.turn, PL1);
    chk("retry_count", bus.move_count, 2);
    reject(4'd0);
    reject(4'd12);
    chk("rej_turn", bus.turn, PL1);
    chk("rej_count", bus.move_count, 2);
    for (int i = 0; i < 7; i++) begin
      play(seq[i], (i % 2 == 0) ? PL1 : PL2, 1'b0, 1'b0);
      if (i == 5) chk("pre_draw_flags", {bus.done, bus.draw}, 0);
    end
    chk("draw_count", bus.move_count, 9);
    chk("draw_flag", bus.draw, 1);
    chk("draw_done", bus.done, 1);
    chk("draw_turn", bus.turn, PL2);
    drop(4'd1);
    chk("done_sticky", bus.done, 1);

    // Game ends on over after the fifth move.
    do_reset();
    play(4'd1, PL1, 1'b0, 1'b0);
    play(4'd2, PL2, 1'b0, 1'b0);
    play(4'd3, PL1, 1'b0, 1'b0);
    play(4'd4, PL2, 1'b0, 1'b0);
    play(4'd5, PL1, 1'b0, 1'b1);
    chk("over_done", bus.done, 1);
    chk("over_draw", bus.draw, 0);
    chk("over_count", bus.move_count, 5);
    drop(4'd6);

    // over seen while idle.
    do_reset();
    bus.over = 1'b1;
    @(negedge clk);
    bus.over = 1'b0;
    chk("idle_over_done", bus.done, 1);

    // Reset during the strobe cycle.
    do_reset();
    play(4'd1, PL1, 1'b0, 1'b0);
    push(K_STROBE, PL2, 4'd7);
    bus.key_code  = 4'd7;
    bus.key_valid = 1'b1;
    @(negedge clk);
    bus.key_valid = 1'b0;
    bus.key_code  = 4'd0;
    #2 reset = 1'b1;
    #1;
    chk("rst_issue_strobe", {bus.move_P1_i, bus.move_P2_i}, 0);
    chk("rst_issue_code", bus.move_P2, 0);
    chk("rst_issue_turn", bus.turn, PL1);
    @(negedge clk);
    reset = 1'b0;

    // Idle timeout, then a key on the expiry cycle.
    play(4'd1, PL1, 1'b0, 1'b0);
    repeat (7) @(negedge clk);
    chk("pre_timeout_turn", bus.turn, PL2);
    push(K_TIMEOUT, 2'b00, 4'd0);
    @(negedge clk);
    chk("timeout_turn", bus.turn, PL1);
    repeat (7) @(negedge clk);
    play(4'd2, PL1, 1'b0, 1'b0);
    chk("race_turn", bus.turn, PL2);
    chk("race_count", bus.move_count, 2);

    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/turn_controller.md
TURN_CONTROLLER -- requirements
Module: turn_controller

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 100_000_000, meaning the number of idle cycles before a turn is forfeited (0 disables the timeout).
REQ-002 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port key_valid  in  1  one-cycle pulse; key_code is valid.
REQ-005 SHALL have port key_code  in  4  requested cell, legal range 1..9.
REQ-006 SHALL have port illegal_move  in  1  registered verdict from the board block, valid one cycle after a strobe.
REQ-007 SHALL have port over  in  1  game-over flag from the board block.
REQ-008 SHALL have ports move_P1_i / move_P2_i  out  1 each  one-cycle move strobes to the board block.
REQ-009 SHALL have ports move_P1 / move_P2  out  4 each  cell code to the board block; 0 when not issuing.
REQ-010 SHALL have port turn  out  2  player to move: 01 = P1, 10 = P2.
REQ-011 SHALL have port move_count  out  4  number of accepted legal moves, range 0..9.
REQ-012 SHALL have ports key_reject / timeout  out  1 each  one-cycle pulses.
REQ-013 SHALL have ports draw / done  out  1 each  sticky end-of-game flags.

Function
REQ-014 SHALL implement the FSM states IDLE, ISSUE, CHECK and DONE, with all outputs registered.
REQ-015 In IDLE, key_valid with key_code in 1..9 SHALL transition to ISSUE; key_code of 0 or 10..15 SHALL pulse key_reject for one cycle and stay in IDLE.
REQ-016 In ISSUE (exactly one cycle), the controller SHALL drive the current player's move_Px = code and move_Px_i = 1; the other player's code and strobe SHALL be 0. The next state is CHECK.
REQ-017 Both move_P1 and move_P2 SHALL be 0 in every state other than ISSUE, because the board block decodes codes without gating by the strobe.
REQ-018 In CHECK, on illegal_move = 1, turn and move_count SHALL be unchanged and the next state SHALL be IDLE; the same player retries.
REQ-019 In CHECK, on illegal_move = 0, move_count SHALL increment and turn SHALL toggle.
REQ-020 In CHECK, the exit SHALL depend on over and the count: over = 1 goes to DONE; a new count of 9 with over = 0 goes to DONE and sets draw = 1; otherwise the next state is IDLE.
REQ-021 over = 1 sampled while in IDLE SHALL transition to DONE (defensive).
REQ-022 key_valid received in ISSUE, CHECK or DONE SHALL be dropped silently, with no key_reject pulse.
REQ-023 The idle timer SHALL count only in IDLE and SHALL clear on leaving IDLE.
REQ-024 When the idle timer reaches TIMEOUT_CYCLES-1, the controller SHALL pulse timeout, toggle turn, keep move_count unchanged, clear the timer and stay in IDLE.
REQ-025 When key_valid and timer expiry coincide, key_valid SHALL win: no timeout pulse, and the move is processed.
REQ-026 DONE SHALL be terminal until reset, with done = 1 and all strobes 0.
REQ-027 Best-case latency from key_valid to the strobe SHALL be 1 cycle, and from the strobe to the next key acceptance SHALL be 2 cycles.

Reset
REQ-028 Reset SHALL asynchronously force state IDLE, turn = 01, move_count = 0, timer = 0, and all strobes, codes, key_reject, timeout, draw and done to 0.
REQ-029 Reset asserted mid-ISSUE SHALL immediately drop the strobe and code, with no partial move retained.

Structure
REQ-030 Shared package ttt_pkg SHALL hold the player encodings (NONE = 00, P1 = 01, P2 = 10), the state enum, and the constants CELL_MIN = 1, CELL_MAX = 9 and MAX_MOVES = 9.
REQ-031 The idle timer SHALL be the sub-module move_timer (inputs: enable, clear; output: expire pulse; parameterised by TIMEOUT_CYCLES), with width $clog2(TIMEOUT_CYCLES+1).

Verification
REQ-032 Scenario: P1 keys 5, illegal_move = 0 -> move_P1 = 5 and move_P1_i for exactly 1 cycle, move_P2 = 0 throughout, then turn = 10 and move_count = 1.
REQ-033 Scenario: P2 keys an already-occupied cell with illegal_move = 1 in CHECK -> turn stays 10, move_count unchanged, next key accepted from P2.
REQ-034 Scenario: key_code = 0 and key_code = 12 in IDLE -> key_reject pulses once each, no strobe issued, state stays IDLE.
REQ-035 Scenario: nine legal moves with over held 0 -> draw = 1, done = 1, move_count = 9, and a further key_valid yields no strobe.
REQ-036 Scenario: TIMEOUT_CYCLES = 8 and no key input -> timeout pulses on the 8th idle cycle and turn toggles; key_valid on that same cycle -> strobe issued, no timeout pulse.
REQ-037 Scenario: over = 1 in CHECK after the 5th move -> done = 1, draw = 0; reset asserted during ISSUE -> strobe and code drop to 0 in the same cycle, turn = 01.
